// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-ported register file.
// Defaults here are the values the top-level parameters fall back to.
package regfile_pkg;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_RD   = 4;
    localparam int DEF_NUM_WR   = 2;
    localparam int DEF_BYPASS   = 1;

    // Wide enough to index any practical number of read or write ports.
    localparam int PORT_IDX_W = 8;
    typedef logic [PORT_IDX_W-1:0] port_idx_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: write, claim, flush and read buses.
// The master drives requests and the slave (regfile_mp) returns read data and status.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]             claim_en;
    logic [NUM_WR-1:0][ADDR_W-1:0] claim_addr;
    logic                          flush;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic                          wr_collision;

    modport master (
        output wr_en, wr_addr, wr_data, claim_en, claim_addr, flush, rd_addr,
        input  rd_data, rd_busy, wr_collision
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, claim_en, claim_addr, flush, rd_addr,
        output rd_data, rd_busy, wr_collision
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit tracker: claims set, writes release, flush clears everything.
// Register 0 is hard-wired not busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_WR   = DEF_NUM_WR,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                          clock,
    input  logic                          ctrl_reset_n,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR-1:0]             claim_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] claim_addr,
    input  logic                          flush,
    output logic [NUM_REGS-1:0]           busy
);
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] claim_hit;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] busy_nxt;

    always_comb begin
        claim_hit = '0;
        wr_hit    = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (claim_en[w]) claim_hit[claim_addr[w]] = 1'b1;
            if (wr_en[w])    wr_hit[wr_addr[w]]       = 1'b1;
        end
        // A claim in the same cycle as the releasing write keeps the register busy.
        busy_nxt    = (busy_q & ~wr_hit) | claim_hit;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n)  busy_q <= '0;
        else if (flush)     busy_q <= '0;
        else                busy_q <= busy_nxt;
    end

    assign busy = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with optional same-cycle write-to-read forwarding,
// destination busy tracking and a registered write-collision flag.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic         clock,
    input  logic         ctrl_reset_n,
    regfile_mp_if.slave  bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             busy;
    logic [NUM_WR-1:0]               wr_valid;
    logic [NUM_WR-1:0]               claim_valid;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_c;
    logic [NUM_RD-1:0]               rd_busy_c;
    logic                            coll_c;
    logic                            coll_q;

    // Writes and claims aimed at register 0 are dropped here so nothing downstream sees them.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_valid[w]    = bus.wr_en[w]    && (bus.wr_addr[w]    != '0);
            claim_valid[w] = bus.claim_en[w] && (bus.claim_addr[w] != '0);
        end
    end

    // Later ports overwrite earlier ones in loop order, so the youngest write wins.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            regs <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++)
                if (wr_valid[w]) regs[bus.wr_addr[w]] <= bus.wr_data[w];
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .wr_en        (wr_valid),
        .wr_addr      (bus.wr_addr),
        .claim_en     (claim_valid),
        .claim_addr   (bus.claim_addr),
        .flush        (bus.flush),
        .busy         (busy)
    );

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data_c[r] = regs[bus.rd_addr[r]];
            rd_busy_c[r] = busy[bus.rd_addr[r]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_valid[w] && (bus.wr_addr[w] == bus.rd_addr[r])) begin
                        rd_data_c[r] = bus.wr_data[w];
                        rd_busy_c[r] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        coll_c = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            for (int j = i + 1; j < NUM_WR; j++)
                if (wr_valid[i] && wr_valid[j] && (bus.wr_addr[i] == bus.wr_addr[j]))
                    coll_c = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) coll_q <= 1'b0;
        else               coll_q <= coll_c;
    end

    assign bus.rd_data      = rd_data_c;
    assign bus.rd_busy      = rd_busy_c;
    assign bus.wr_collision = coll_q;
endmodule
